// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Walks the sensor matrix cell by cell once the ADC reports ready: holds the
// row/column mux selects, waits for the analog path to settle, fires one
// conversion, captures the result and offers it (tagged with its cell) on a
// valid/ready stream. A missing conversion result aborts the frame after
// TIMEOUT cycles; losing adc_ready discards the partial frame.
module adc_scan_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int SETTLE  = 4,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 200
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              adc_ready_i,
    input  logic              scan_en_i,
    output logic              adc_start_o,
    input  logic              adc_done_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic [7:0]        row_sel_o,
    output logic [7:0]        col_sel_o,
    output logic [DATA_W-1:0] sample_data_o,
    output logic [7:0]        sample_row_o,
    output logic [7:0]        sample_col_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              frame_done_o,
    output logic              timeout_err_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;

    localparam logic [7:0]  LAST_ROW   = 8'(ROWS - 1);
    localparam logic [7:0]  LAST_COL   = 8'(COLS - 1);
    localparam logic [7:0]  SETTLE_END = 8'(SETTLE - 1);
    localparam logic [15:0] TMO_END    = 16'(TIMEOUT - 1);

    logic [2:0]        state_q,        state_d;
    logic [7:0]        settle_cnt_q,   settle_cnt_d;
    logic [15:0]       tmo_cnt_q,      tmo_cnt_d;
    logic [7:0]        row_q,          row_d;
    logic [7:0]        col_q,          col_d;
    logic              adc_start_q,    adc_start_d;
    logic [DATA_W-1:0] sample_data_q,  sample_data_d;
    logic [7:0]        sample_row_q,   sample_row_d;
    logic [7:0]        sample_col_q,   sample_col_d;
    logic              sample_valid_q, sample_valid_d;
    logic              frame_done_q,   frame_done_d;
    logic              timeout_err_q,  timeout_err_d;

    logic last_cell;

    assign last_cell = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        // NOTE: every _d takes its _q value (or pulse default) first, so no branch can leave a latch behind.
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        row_d          = row_q;
        col_d          = col_q;
        sample_data_d  = sample_data_q;
        sample_row_d   = sample_row_q;
        sample_col_d   = sample_col_q;
        sample_valid_d = sample_valid_q;
        adc_start_d    = 1'b0;
        frame_done_d   = 1'b0;
        timeout_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                row_d        = 8'd0;
                col_d        = 8'd0;
                settle_cnt_d = 8'd0;
                tmo_cnt_d    = 16'd0;
                if (adc_ready_i && scan_en_i) begin
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                // Start pulse is registered, so it is raised on the edge that enters START.
                if (settle_cnt_q == SETTLE_END) begin
                    settle_cnt_d = 8'd0;
                    adc_start_d  = 1'b1;
                    state_d      = S_START;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            S_START: begin
                tmo_cnt_d = 16'd0;
                state_d   = S_CONVERT;
            end

            S_CONVERT: begin
                if (adc_done_i) begin
                    sample_data_d  = adc_data_i;
                    sample_row_d   = row_q;
                    sample_col_d   = col_q;
                    sample_valid_d = 1'b1;
                    state_d        = S_OUTPUT;
                end else if (tmo_cnt_q == TMO_END) begin
                    timeout_err_d = 1'b1;
                    row_d         = 8'd0;
                    col_d         = 8'd0;
                    tmo_cnt_d     = 16'd0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            S_OUTPUT: begin
                if (sample_ready_i) begin
                    sample_valid_d = 1'b0;
                    frame_done_d   = last_cell;
                    state_d        = S_NEXT;
                end
            end

            S_NEXT: begin
                // Column advances first; row steps when the column wraps.
                state_d = S_SETTLE;
                if (col_q == LAST_COL) begin
                    col_d = 8'd0;
                    if (row_q == LAST_ROW) begin
                        row_d   = 8'd0;
                        state_d = scan_en_i ? S_SETTLE : S_IDLE;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing the ADC discards everything in flight, including a pending handshake.
        if ((state_q != S_IDLE) && !adc_ready_i) begin
            state_d        = S_IDLE;
            row_d          = 8'd0;
            col_d          = 8'd0;
            settle_cnt_d   = 8'd0;
            tmo_cnt_d      = 16'd0;
            sample_valid_d = 1'b0;
            adc_start_d    = 1'b0;
            frame_done_d   = 1'b0;
            timeout_err_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values together.
        if (reset_i) begin
            state_q        <= S_IDLE;
            settle_cnt_q   <= 8'd0;
            tmo_cnt_q      <= 16'd0;
            row_q          <= 8'd0;
            col_q          <= 8'd0;
            adc_start_q    <= 1'b0;
            sample_data_q  <= '0;
            sample_row_q   <= 8'd0;
            sample_col_q   <= 8'd0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            row_q          <= row_d;
            col_q          <= col_d;
            adc_start_q    <= adc_start_d;
            sample_data_q  <= sample_data_d;
            sample_row_q   <= sample_row_d;
            sample_col_q   <= sample_col_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign adc_start_o    = adc_start_q;
    assign row_sel_o      = row_q;
    assign col_sel_o      = col_q;
    assign sample_data_o  = sample_data_q;
    assign sample_row_o   = sample_row_q;
    assign sample_col_o   = sample_col_q;
    assign sample_valid_o = sample_valid_q;
    assign frame_done_o   = frame_done_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer
// Drives adc_scan_sequencer with a small ADC model (mux-dependent data plus
// random noise, random conversion delay, stray adc_done pulses) and a
// scoreboard: each conversion result the ADC model hands out is queued with
// the cell the scan order says it belongs to; a monitor pops and compares
// whenever the DUT presents a sample.
module tb_adc_scan_sequencer;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int SETTLE  = 4;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 200;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              adc_ready_i;
    logic              scan_en_i;
    logic              adc_start_o;
    logic              adc_done_i;
    logic [DATA_W-1:0] adc_data_i;
    logic [7:0]        row_sel_o;
    logic [7:0]        col_sel_o;
    logic [DATA_W-1:0] sample_data_o;
    logic [7:0]        sample_row_o;
    logic [7:0]        sample_col_o;
    logic              sample_valid_o;
    logic              sample_ready_i;
    logic              frame_done_o;
    logic              timeout_err_o;

    adc_scan_sequencer #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SETTLE  (SETTLE),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .adc_ready_i    (adc_ready_i),
        .scan_en_i      (scan_en_i),
        .adc_start_o    (adc_start_o),
        .adc_done_i     (adc_done_i),
        .adc_data_i     (adc_data_i),
        .row_sel_o      (row_sel_o),
        .col_sel_o      (col_sel_o),
        .sample_data_o  (sample_data_o),
        .sample_row_o   (sample_row_o),
        .sample_col_o   (sample_col_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .frame_done_o   (frame_done_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int c;
        int d;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    // ADC / scan-order model state
    int  mr, mc;         // cell the next conversion belongs to
    int  pend;           // cycles until the ADC answers
    bit  pend_live;      // answer belongs to a conversion the DUT still wants
    bit  resp_en;        // ADC answers start pulses
    int  cur_d;          // conversion delay D
    bit  fd_exp;         // frame_done expected this cycle
    int  fd_count;
    int  tmo_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        pend_live = 1'b0;
        mr        = 0;
        mc        = 0;
        fd_exp    = 1'b0;
    endtask

    // One negedge step: ADC model at +1, scoreboard monitor at +2.
    task automatic agent_step();
        exp_t e;
        int   noise;
        @(negedge clk);
        #1;
        adc_done_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                noise      = $urandom_range(0, 15);
                adc_data_i = DATA_W'(noise * 256 + 16 * int'(row_sel_o) + int'(col_sel_o));
                adc_done_i = 1'b1;
                if (pend_live) begin
                    e.r    = mr;
                    e.c    = mc;
                    e.d    = noise * 256 + 16 * mr + mc;
                    e.last = (mr == ROWS - 1) && (mc == COLS - 1);
                    exp_q.push_back(e);
                    if (mc == COLS - 1) begin
                        mc = 0;
                        mr = (mr == ROWS - 1) ? 0 : mr + 1;
                    end else begin
                        mc = mc + 1;
                    end
                end
            end
        end else if (resp_en && !adc_start_o && ($urandom_range(0, 5) == 0)) begin
            // Stray completion while no conversion is outstanding.
            adc_data_i = DATA_W'($urandom);
            adc_done_i = 1'b1;
        end
        if (adc_start_o && resp_en) begin
            pend      = cur_d;
            pend_live = 1'b1;
        end

        #1;
        if (!reset_i) begin
            check("frame_done", 32'(frame_done_o), 32'(fd_exp));
            fd_exp = 1'b0;
            if (frame_done_o) fd_count++;
            if (timeout_err_o) tmo_count++;
            if (sample_valid_o) begin
                check("start_while_valid", 32'(adc_start_o), 32'd0);
                if (exp_q.size() == 0) begin
                    check("sample_unexpected", 32'(sample_valid_o), 32'd0);
                end else begin
                    check("sample_row", 32'(sample_row_o), 32'(exp_q[0].r));
                    check("sample_col", 32'(sample_col_o), 32'(exp_q[0].c));
                    check("sample_data", 32'(sample_data_o), 32'(exp_q[0].d));
                    if (sample_ready_i && adc_ready_i) begin
                        fd_exp = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic wait_start(output int t);
        int k;
        k = 0;
        t = -1;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (adc_start_o) begin
                t = cyc;
                return;
            end
        end
        check("adc_start_within_budget", 32'(adc_start_o), 32'd1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (sample_valid_o) return;
        end
        check("sample_valid_within_budget", 32'(sample_valid_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adc_start"},    32'(adc_start_o),    32'd0);
        check({tag, "_row_sel"},      32'(row_sel_o),      32'd0);
        check({tag, "_col_sel"},      32'(col_sel_o),      32'd0);
        check({tag, "_sample_data"},  32'(sample_data_o),  32'd0);
        check({tag, "_sample_row"},   32'(sample_row_o),   32'd0);
        check({tag, "_sample_col"},   32'(sample_col_o),   32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid_o), 32'd0);
        check({tag, "_frame_done"},   32'(frame_done_o),   32'd0);
        check({tag, "_timeout_err"},  32'(timeout_err_o),  32'd0);
    endtask

    task automatic run_sequence();
        int t_s, t_prev, t_ref, lat, k, n, fd0;
        int period;
        period = SETTLE + cur_d + 3;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_i   = 1'b0;
        scan_en_i = 1'b1;

        // Gating: scan enabled but ADC not ready
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gated_adc_start", 32'(adc_start_o),    32'd0);
            check("gated_valid",     32'(sample_valid_o), 32'd0);
            check("gated_row_sel",   32'(row_sel_o),      32'd0);
            check("gated_col_sel",   32'(col_sel_o),      32'd0);
        end
        adc_ready_i = 1'b1;
        t_ref       = cyc;
        wait_start(t_s);
        check("first_start_latency", 32'(t_s - t_ref), 32'(1 + SETTLE));

        // sample_valid rises the cycle after the captured adc_done
        for (int i = 1; i <= cur_d + 1; i++) begin
            @(negedge clk);
            check("valid_latency", 32'(sample_valid_o), 32'(i == cur_d + 1));
        end

        // Basic frame timing, across the frame boundary
        t_prev = t_s;
        for (int i = 1; i <= ROWS * COLS; i++) begin
            wait_start(t_s);
            check("cell_period", 32'(t_s - t_prev), 32'(period));
            t_prev = t_s;
        end
        check("frames_after_first", 32'(fd_count), 32'd1);

        // Backpressure on cell (1,2) of the second frame
        for (int i = 1; i <= 6; i++) begin
            wait_start(t_s);
            check("cell_period", 32'(t_s - t_prev), 32'(period));
            t_prev = t_s;
        end
        sample_ready_i = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("valid_held_in_stall", 32'(sample_valid_o), 32'd1);
        end
        sample_ready_i = 1'b1;
        wait_start(t_s);
        check("stall_period", 32'(t_s - t_prev), 32'(period + 5));
        t_prev = t_s;
        wait_start(t_s);
        check("cell_period_after_stall", 32'(t_s - t_prev), 32'(period));

        // Random backpressure and conversion delays
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            sample_ready_i = ($urandom_range(0, 3) != 0);
            if (i % 37 == 0) cur_d = $urandom_range(1, 6);
        end
        sample_ready_i = 1'b1;
        cur_d          = 3;

        // Timeout: the ADC ignores the next start pulse
        wait_start(t_s);
        resp_en = 1'b0;
        lat = 0;
        k   = 0;
        while (k < TIMEOUT + 50 && lat == 0) begin
            @(negedge clk);
            k++;
            if (timeout_err_o) lat = k;
        end
        check("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
        check("timeout_row_cleared", 32'(row_sel_o), 32'd0);
        check("timeout_col_cleared", 32'(col_sel_o), 32'd0);
        flush_model();
        resp_en = 1'b1;
        t_ref   = cyc;
        @(negedge clk);
        check("timeout_pulse_width", 32'(timeout_err_o), 32'd0);
        wait_start(t_s);
        check("restart_after_timeout", 32'(t_s - t_ref), 32'(1 + SETTLE));
        check("timeout_pulses", 32'(tmo_count), 32'd1);

        // Abort: drop adc_ready while cell (2,1) is presented
        for (int i = 1; i <= 9; i++) wait_start(t_s);
        sample_ready_i = 1'b0;
        wait_valid();
        fd0         = fd_count;
        adc_ready_i = 1'b0;
        @(posedge clk);
        #1;
        flush_model();
        @(negedge clk);
        check("abort_valid",   32'(sample_valid_o), 32'd0);
        check("abort_row_sel", 32'(row_sel_o),      32'd0);
        check("abort_col_sel", 32'(col_sel_o),      32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_start", 32'(adc_start_o), 32'd0);
        end
        check("abort_no_frame_done", 32'(fd_count - fd0), 32'd0);
        sample_ready_i = 1'b1;
        adc_ready_i    = 1'b1;
        t_ref          = cyc;
        wait_start(t_s);
        check("restart_after_abort", 32'(t_s - t_ref), 32'(1 + SETTLE));

        // scan_en drops at cell 4: frame completes, then stops
        for (int i = 1; i <= 4; i++) wait_start(t_s);
        scan_en_i = 1'b0;
        fd0 = fd_count;
        n   = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (adc_start_o) n++;
        end
        check("starts_after_scan_drop", 32'(n), 32'(ROWS * COLS - 5));
        check("frame_done_after_drop", 32'(fd_count - fd0), 32'd1);
        check("stopped_row_sel", 32'(row_sel_o), 32'd0);
        check("stopped_col_sel", 32'(col_sel_o), 32'd0);
        check("stopped_valid",   32'(sample_valid_o), 32'd0);

        // Reset in CONVERT; the late adc_done must be ignored
        scan_en_i = 1'b1;
        t_ref     = cyc;
        wait_start(t_s);
        check("rescan_latency", 32'(t_s - t_ref), 32'(1 + SETTLE));
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        flush_model();
        @(negedge clk);
        reset_i = 1'b0;
        check_reset_outputs("reset_mid_convert");
        t_ref = cyc;
        wait_start(t_s);
        check("start_after_reset", 32'(t_s - t_ref), 32'(1 + SETTLE));
        for (int i = 0; i < 3; i++) wait_start(t_s);
        repeat (12) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        adc_ready_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_i        = 1'b1;
        adc_ready_i    = 1'b0;
        scan_en_i      = 1'b0;
        sample_ready_i = 1'b1;
        adc_done_i     = 1'b0;
        adc_data_i     = '0;
        mr             = 0;
        mc             = 0;
        pend           = 0;
        pend_live      = 1'b0;
        resp_en        = 1'b1;
        cur_d          = 3;
        fd_exp         = 1'b0;
        fd_count       = 0;
        tmo_count      = 0;
        fork
            forever agent_step();
            run_sequence();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Scans the pressure-sensor matrix through the ADC once the ADC init controller reports ready. Steps row/column mux selects, lets the analog path settle, and triggers one conversion per cell. Captures each result and presents it, tagged with its row and column, on a valid/ready stream toward the packetiser/UART path. Sits between the ADC init controller (status output) and the frame-transmit logic.

## Interface
Parameters:
- ROWS, 16: matrix rows (2..256)
- COLS, 16: matrix columns (2..256)
- SETTLE, 4: cycles the mux selects are held before each conversion start (1..255)
- DATA_W, 12: ADC sample width
- TIMEOUT, 200: max cycles waiting for adc_done before abort (1..65535)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- adc_ready  in  1  ADC initialised (status from init controller); level
- scan_en  in  1  continuous-scan enable; level
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  conversion complete, qualifies adc_data (single-cycle or level)
- adc_data  in  DATA_W  conversion result
- row_sel  out  8  row mux select
- col_sel  out  8  column mux select
- sample_data  out  DATA_W  captured sample
- sample_row  out  8  row of sample_data
- sample_col  out  8  column of sample_data
- sample_valid  out  1  sample presented
- sample_ready  in  1  downstream accepts
- frame_done  out  1  one-cycle pulse after last cell of a frame is accepted
- timeout_err  out  1  one-cycle pulse on conversion timeout

## Operation
- States: IDLE, SETTLE, START, CONVERT, OUTPUT, NEXT. All outputs registered.
- IDLE:
  - row_sel = col_sel = 0; settle/timeout counters cleared.
  - Go to SETTLE when adc_ready && scan_en.
- SETTLE:
  - Counter increments each cycle.
  - After SETTLE cycles in state, go to START. row_sel/col_sel do not change in SETTLE, START or CONVERT.
- START:
  - adc_start = 1 for exactly this one cycle.
  - Go to CONVERT; timeout counter cleared.
- CONVERT:
  - Wait for adc_done sampled high.
  - On that edge: sample_data <= adc_data, sample_row <= row_sel, sample_col <= col_sel; go to OUTPUT.
  - If the timeout counter reaches TIMEOUT with no adc_done: pulse timeout_err, abort frame, go to IDLE.
- OUTPUT:
  - sample_valid = 1; sample_data/row/col held stable.
  - On sample_valid && sample_ready, go to NEXT.
- NEXT:
  - Column-major-within-row advance: col+1; at col = COLS-1, col wraps to 0 and row+1.
  - At (ROWS-1, COLS-1): pulse frame_done, wrap to (0,0); if scan_en go to SETTLE, else go to IDLE.
  - Otherwise go to SETTLE.
- scan_en dropping mid-frame: the current frame completes; the sequencer stops at the frame boundary.
- adc_ready dropping in any non-IDLE state:
  - Go to IDLE next cycle; sample_valid drops without a handshake; no frame_done.
  - The partial frame is discarded; the next scan restarts at (0,0).
- adc_done outside CONVERT is ignored.

## Timing
- Reset values: adc_start 0, row_sel 0, col_sel 0, sample_data 0, sample_row 0, sample_col 0, sample_valid 0, frame_done 0, timeout_err 0; state IDLE.
- Reset mid-operation: all of the above apply on the next edge, regardless of state.
- IDLE to first adc_start: 1 + SETTLE cycles after the edge where adc_ready && scan_en is sampled high.
- Per-cell period with sample_ready tied high and adc_done arriving D cycles after the START cycle: SETTLE + 1 + D + 1 + 1 cycles.
- Each stall cycle of sample_ready adds one cycle.
- sample_valid asserts the cycle after adc_done is captured.
- frame_done asserts the cycle after the final handshake (the NEXT cycle).
- timeout_err asserts TIMEOUT cycles after entry to CONVERT. IDLE is entered on the same edge.

## Test plan
- Basic frame (ROWS=COLS=4, SETTLE=4, adc_done 3 cycles after start, adc_data = 16·row+col, ready high) -> 16 samples in order (0,0)…(3,3) with matching data; each period 10 cycles; one frame_done; next frame restarts at (0,0).
- Backpressure (sample_ready low 5 cycles on cell (1,2)) -> sample_valid and data held stable; no new adc_start until the handshake; period grows by 5.
- Gating (adc_ready low, scan_en high) -> no adc_start, outputs stay at reset values. Raise adc_ready -> first adc_start exactly 1+SETTLE cycles later.
- Timeout (adc_done never arrives, TIMEOUT=200) -> timeout_err pulse 200 cycles after CONVERT entry; sample_valid never asserts; rescan restarts at (0,0).
- Abort and stop (drop adc_ready during OUTPUT at cell (2,1)) -> IDLE next cycle, sample_valid 0, no frame_done. Separately, drop scan_en mid-frame -> frame completes with frame_done, then IDLE.
- Reset mid-CONVERT -> all outputs at reset values next cycle; adc_done arriving afterward is ignored.
